// File: rtl/rx_bit_timer.sv
// Receive bit timer for the full-speed USB receiver.
// Recovers the bit phase from D+ transitions and emits a one-cycle sample
// strobe per data bit. Bit-stuffed bits are removed (and a stuffed 1 is
// flagged as an error). A pulse is raised after every completed byte.
module rx_bit_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3,
  parameter int STUFF_LEN    = 6
) (
  input  logic clk,
  input  logic n_rst,
  input  logic rcving,
  input  logic d_edge,
  input  logic d_orig,
  input  logic eop,
  output logic shift_en,
  output logic stuff_bit,
  output logic stuff_err,
  output logic byte_received
);

  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam int OW = $clog2(STUFF_LEN + 1);

  localparam logic [PW-1:0] PHASE_MAX    = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PHASE_SAMPLE = PW'(SAMPLE_POINT);
  localparam logic [PW-1:0] PHASE_ONE    = PW'(1);
  localparam logic [OW-1:0] ONES_MAX     = OW'(STUFF_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [OW-1:0] ones_cnt_q, ones_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          byte_received_q, byte_received_d;

  logic tick;
  logic stuff;

  // Sample-point decode: purely combinational so the strobe has no added latency.
  always_comb begin
    tick      = (state_q == RUN) & rcving & (phase_q == PHASE_SAMPLE);
    stuff     = (ones_cnt_q == ONES_MAX);
    shift_en  = tick & ~stuff;
    stuff_bit = tick & stuff;
    stuff_err = tick & stuff & d_orig;
  end

  assign byte_received = byte_received_q;

  // Next-state logic: FSM, phase tracking, stuffing and bit counting.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    ones_cnt_d = ones_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    // tick is gated by rcving, so a byte completing as rcving falls is dropped.
    byte_received_d = shift_en & ~eop & (bit_cnt_q == 3'd7) & rcving;

    if (!rcving) begin
      state_d    = IDLE;
      phase_d    = '0;
      ones_cnt_d = '0;
      bit_cnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = SYNC;
        SYNC: begin
          if (d_edge) begin
            state_d = RUN;
            phase_d = PHASE_ONE;
          end
        end
        RUN: begin
          // The edge cycle itself is phase 0, so resync lands on phase 1.
          if (d_edge)                   phase_d = PHASE_ONE;
          else if (phase_q == PHASE_MAX) phase_d = '0;
          else                          phase_d = phase_q + PHASE_ONE;
        end
        default: state_d = IDLE;
      endcase

      if (tick) begin
        if (stuff || eop)  ones_cnt_d = '0;
        else if (d_orig)   ones_cnt_d = ones_cnt_q + OW'(1);
        else               ones_cnt_d = '0;
      end

      // Stuffed bits never reach here because shift_en excludes them.
      if (shift_en) begin
        if (eop) bit_cnt_d = '0;
        else     bit_cnt_d = bit_cnt_q + 3'd1;
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      phase_q         <= '0;
      ones_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      byte_received_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      ones_cnt_q      <= ones_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      byte_received_q <= byte_received_d;
    end
  end

endmodule

// File: doc/rx_bit_timer.md
Name: rx_bit_timer

Overview:
- Receive bit-timing stage of the USB full-speed receiver.
- Recovers bit phase from `d_edge`, the transition pulse from the edge detector on the synchronized D+/D- lines.
- Generates the one-cycle `shift_en` strobe consumed by the receive shift register and by `rx_eop`. Removes bit-stuffed bits and flags stuff errors.
- Counts data bits and pulses `byte_received` per completed byte to the receive controller.

Parameters:
- CLKS_PER_BIT, 8, clk cycles per USB bit time; legal range 4..16.
- SAMPLE_POINT, 3, phase at which a bit is sampled; legal range 1..CLKS_PER_BIT-1.
- STUFF_LEN, 6, consecutive decoded 1s after which the next bit is a stuffed bit.

Ports:
- clk, input, 1, system clock.
- n_rst, input, 1, asynchronous active-low reset.
- rcving, input, 1, packet reception active (from the receive controller).
- d_edge, input, 1, one-cycle pulse on a D+ transition.
- d_orig, input, 1, NRZI-decoded bit value; valid at the sample point.
- eop, input, 1, end-of-packet detected (from `rx_eop`).
- shift_en, output, 1, one-cycle data-bit sample strobe.
- stuff_bit, output, 1, one-cycle strobe at a sample point whose bit is stuffed (discarded).
- stuff_err, output, 1, stuffed bit was 1 (protocol violation).
- byte_received, output, 1, one-cycle pulse after the 8th data bit of a byte.

Behaviour:
- Reset: clk, n_rst asynchronous active-low. State IDLE; phase, ones_cnt and bit_cnt = 0; byte_received = 0. All outputs are 0 in reset.
- Internal registers:
  - phase: $clog2(CLKS_PER_BIT) bits.
  - ones_cnt: $clog2(STUFF_LEN+1) bits.
  - bit_cnt: 3 bits.
- FSM transitions:
  - IDLE -> SYNC when rcving=1.
  - SYNC -> RUN on d_edge=1; phase <= 1.
  - Any state -> IDLE on the next edge when rcving=0. All counters clear; a byte_received that would have been set that cycle is dropped.
- Phase update in RUN:
  - If d_edge=1: phase <= 1 (the edge cycle counts as phase 0).
  - Otherwise: phase <= (phase == CLKS_PER_BIT-1) ? 0 : phase+1.
  - A d_edge in the sample-point cycle does not cancel that sample.
- tick = (state==RUN) & rcving & (phase==SAMPLE_POINT). Combinational, no added latency. With defaults, tick is high 3 cycles after the d_edge cycle and then every 8 cycles absent edges.
- Output decode:
  - stuff = (ones_cnt == STUFF_LEN).
  - shift_en = tick & ~stuff.
  - stuff_bit = tick & stuff.
  - stuff_err = stuff_bit & d_orig.
- ones_cnt update on tick:
  - If stuff or eop: 0.
  - Else if d_orig=1: +1.
  - Else: 0.
- bit_cnt update on shift_en:
  - If eop=1: cleared (partial byte discarded, no byte_received).
  - Else: bit_cnt <= bit_cnt+1, wrapping 7->0.
  - Stuffed bits do not advance bit_cnt.
- byte_received (registered): next-cycle value = shift_en & ~eop & (bit_cnt==7) & rcving. Asserted exactly 1 cycle, in the cycle after the 8th shift_en.
- eop does not suppress shift_en; `rx_eop` requires the strobe to qualify SE0.
- stuff_err is informational only; timing continues. The receive controller decides whether to abort.
- SYNC with no edge: stays in SYNC indefinitely; no strobes are produced.

Test Plan:
1. Reset, rcving=1, single d_edge at cycle 10, no further edges -> shift_en pulses at cycles 13, 21, 29, ...; stuff_bit, stuff_err and byte_received stay 0 until the 8th shift.
2. Eight bits with edges every 8 cycles, d_orig pattern 0x2A -> 8 shift_en pulses, each 1 cycle wide. byte_received is high for exactly 1 cycle, one cycle after the 8th shift_en.
3. Drift: edges at 9- and 7-cycle spacing -> each shift_en occurs exactly 3 cycles after the most recent d_edge. No double strobes, no missed strobes.
4. Stuffing: d_orig=1 for 6 consecutive ticks, then 0 -> 7th tick gives stuff_bit=1, shift_en=0, stuff_err=0. bit_cnt is unchanged; byte_received fires only after 8 non-stuffed bits. Same sequence with the 7th bit d_orig=1 -> stuff_err=1 for 1 cycle.
5. eop=1 at the tick of the 5th bit -> shift_en still pulses and bit_cnt clears. No byte_received; the next byte needs 8 fresh shifts.
6. rcving dropped in the same cycle as the 8th shift_en -> byte_received stays 0 and the block is in IDLE next cycle. Re-asserting rcving waits in SYNC for d_edge. Asserting n_rst mid-byte clears all outputs immediately.
